regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the kanade32 core: NUM_RD combinational read ports, two
//  write ports, optional hardwired zero register, optional write-to-read bypass and a per-register
//  pending (hazard) scoreboard. Storage is cleared by a sequential sweep after reset. Sits between
//  decode (reads, pend_set) and writeback (wr0 = ALU, wr1 = load).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register index width; NREG = 2**ADDR_W entries
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: entry 0 always reads 0, writes to it and pend_set on it are ignored
//  BYPASS    1   1: a same-cycle write is forwarded to matching read ports
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-high reset
//  wr0_en     in   1              write port 0 enable
//  wr0_addr   in   ADDR_W         write port 0 index
//  wr0_data   in   DATA_W         write port 0 data
//  wr1_en     in   1              write port 1 enable (priority port)
//  wr1_addr   in   ADDR_W         write port 1 index
//  wr1_data   in   DATA_W         write port 1 data
//  pend_set   in   1              mark pend_addr as awaiting a write
//  pend_addr  in   ADDR_W         register to mark pending
//  rd_addr    in   NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//  rd_pend    out  NUM_RD         1: register read on port k has an outstanding producer
//  init_busy  out  1              1 while the clear sweep runs; core must stall
// BEHAVIOUR
//  Reset: init_busy=1 in the cycle after reset is sampled high, sweep index=0, all pending bits=0.
//   rd_data=0 and rd_pend=0 while init_busy=1.
//  Sweep: each cycle with init_busy=1 writes 0 to entry[idx], idx++. The entry NREG-1 write
//   occurs in the last sweep cycle; init_busy falls the cycle after. Sweep takes exactly NREG cycles.
//   Writes and pend_set are ignored during the sweep. Reset during the sweep restarts at idx=0.
//  Read: combinational, 0-cycle latency. Address 0 with ZERO_REG=1 -> 0, rd_pend=0.
//   BYPASS=1: matching enabled write this cycle returns its data (wr1 over wr0) and rd_pend=0.
//   BYPASS=0: returns the stored (pre-edge) value and pending bit.
//  Write: entry updated at the clock edge. Both ports enabled on the same address: wr1_data stored.
//   With ZERO_REG=1, writes to entry 0 are dropped.
//  Pending: an enabled write to addr clears pend[addr]. pend_set sets pend[pend_addr].
//   pend_set and a clearing write on the same address in the same cycle: the bit ends set
//   (new producer wins). pend_set does not affect rd_pend until the next cycle.
//  Every state element is synchronous; there is no asynchronous path from reset.
// TESTING
//  1 reset 1 cycle, release -> init_busy=1 for exactly 32 cycles; all 32 entries read 0 after.
//  2 reset at sweep cycle 10 -> sweep restarts, init_busy stays 1 for a further 32 cycles.
//    wr0 5<-0xDEADBEEF at sweep cycle 5 -> entry 5 reads 0 after the sweep.
//  3 wr0 7<-0x11111111 and wr1 7<-0x22222222 in the same cycle -> rd port 0 on 7 reads
//    0x22222222 that cycle (BYPASS=1) and every cycle after. With BYPASS=0 it reads 0 that
//    cycle and 0x22222222 after.
//  4 wr1 0<-0xFFFFFFFF and pend_set 0 (ZERO_REG=1) -> entry 0 reads 0 and rd_pend=0 forever.
//  5 pend_set 9 -> rd_pend=1 on r9 next cycle. Later wr0 9<-0x5 plus pend_set 9 in the same
//    cycle -> r9 reads 0x5 and rd_pend stays 1. A further write to 9 clears it.
//  6 NUM_RD=3, all ports read 31, 30, 31 after writes 0xA, 0xB -> 0xA, 0xB, 0xA with no cross-talk.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports (wr1 has priority), pending scoreboard.
// Latency: reads are 0-cycle combinational; writes and pending updates take effect at the next clock edge.
// Backpressure: none on the ports; init_busy_o stays high during the post-reset clear sweep and the core must stall.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  input  logic                     pend_set_i,
  input  logic [ADDR_W-1:0]        pend_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  output logic                     init_busy_o
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic              init_busy_q, init_busy_d;
  logic [ADDR_W-1:0] sweep_idx_q, sweep_idx_d;

  // Entry 0 is hardwired when ZERO_REG is set, so writes and pend_set on it are dropped.
  logic wr0_ok, wr1_ok, pend_ok;
  assign wr0_ok  = wr0_en_i   && !(ZERO_REG != 0 && wr0_addr_i  == '0);
  assign wr1_ok  = wr1_en_i   && !(ZERO_REG != 0 && wr1_addr_i  == '0);
  assign pend_ok = pend_set_i && !(ZERO_REG != 0 && pend_addr_i == '0);

  // Sweep control: advance the clear index each busy cycle, drop busy after the last entry.
  always_comb begin
    init_busy_d = init_busy_q;
    sweep_idx_d = sweep_idx_q;
    if (init_busy_q) begin
      sweep_idx_d = sweep_idx_q + 1'b1;
      if (sweep_idx_q == LAST_IDX) begin
        init_busy_d = 1'b0;
      end
    end
  end

  // Sweep state registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      init_busy_q <= 1'b1;
      sweep_idx_q <= '0;
    end else begin
      init_busy_q <= init_busy_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // Pending bits: a write clears, pend_set applied last so a new producer wins over a same-cycle write.
  always_comb begin
    pend_d = pend_q;
    if (!init_busy_q) begin
      if (wr0_en_i) pend_d[wr0_addr_i] = 1'b0;
      if (wr1_en_i) pend_d[wr1_addr_i] = 1'b0;
      if (pend_ok)  pend_d[pend_addr_i] = 1'b1;
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Storage: the sweep owns the array while busy; otherwise wr1 is applied after wr0 so it wins on collision.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (init_busy_q) begin
        mem_q[sweep_idx_q] <= '0;
      end else begin
        if (wr0_ok) mem_q[wr0_addr_i] <= wr0_data_i;
        if (wr1_ok) mem_q[wr1_addr_i] <= wr1_data_i;
      end
    end
  end

  assign init_busy_o = init_busy_q;

  logic [DATA_W-1:0] rd_dat [NUM_RD];
  logic              rd_pnd [NUM_RD];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr_i[g*ADDR_W +: ADDR_W];

    // Read mux: busy and hardwired zero first, then same-cycle bypass (wr1 over wr0), then storage.
    always_comb begin
      rd_dat[g] = mem_q[ra];
      rd_pnd[g] = pend_q[ra];
      if (init_busy_q || (ZERO_REG != 0 && ra == '0)) begin
        rd_dat[g] = '0;
        rd_pnd[g] = 1'b0;
      end else if (BYPASS != 0 && wr1_en_i && wr1_addr_i == ra) begin
        rd_dat[g] = wr1_data_i;
        rd_pnd[g] = 1'b0;
      end else if (BYPASS != 0 && wr0_en_i && wr0_addr_i == ra) begin
        rd_dat[g] = wr0_data_i;
        rd_pnd[g] = 1'b0;
      end
    end

    assign rd_data_o[g*DATA_W +: DATA_W] = rd_dat[g];
    assign rd_pend_o[g]                  = rd_pnd[g];
  end

endmodule
